// File: rtl/rmw_long_latency_rd_sched_if.sv
// Interface bundling the requester, table-read and response signals of the
// long-latency read scheduler.
//   slave  : the scheduler side (takes requests and completions, drives grants,
//            table reads, responses and status)
//   master : the environment side (requesters and the table lookup engine)
// Signals:
//   req_vld_r / req_id_r        per-requester read request and table index
//   req_rdy_w                   one-hot combinational grant
//   tbl_rd_r / _id_r / _itag_r  registered table read strobe, index, issue tag
//   tbl_rd_word_vld_r / _word_r / _ctag_r   table completion
//   rsp_vld_r / rsp_word_r / rsp_tag_r      registered routed completion
//   busy_r / err_r              any tag outstanding / sticky unallocated-completion
interface rmw_long_latency_rd_sched_if #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 3,
    parameter int ID_W   = 8,
    parameter int WORD_W = 32
);
    logic [N_REQ-1:0]      req_vld_r;
    logic [N_REQ*ID_W-1:0] req_id_r;
    logic [N_REQ-1:0]      req_rdy_w;
    logic                  tbl_rd_r;
    logic [ID_W-1:0]       tbl_rd_id_r;
    logic [TAG_W-1:0]      tbl_rd_itag_r;
    logic                  tbl_rd_word_vld_r;
    logic [WORD_W-1:0]     tbl_rd_word_r;
    logic [TAG_W-1:0]      tbl_rd_ctag_r;
    logic [N_REQ-1:0]      rsp_vld_r;
    logic [WORD_W-1:0]     rsp_word_r;
    logic [TAG_W-1:0]      rsp_tag_r;
    logic                  busy_r;
    logic                  err_r;

    modport slave (
        input  req_vld_r, req_id_r, tbl_rd_word_vld_r, tbl_rd_word_r, tbl_rd_ctag_r,
        output req_rdy_w, tbl_rd_r, tbl_rd_id_r, tbl_rd_itag_r,
               rsp_vld_r, rsp_word_r, rsp_tag_r, busy_r, err_r
    );

    modport master (
        output req_vld_r, req_id_r, tbl_rd_word_vld_r, tbl_rd_word_r, tbl_rd_ctag_r,
        input  req_rdy_w, tbl_rd_r, tbl_rd_id_r, tbl_rd_itag_r,
               rsp_vld_r, rsp_word_r, rsp_tag_r, busy_r, err_r
    );
endinterface

// File: rtl/rmw_long_latency_rd_sched.sv
// Long-latency table read scheduler.
// Shares one table read port between N_REQ requesters: round-robin picks one
// requester per cycle, allocates the lowest free in-flight tag, issues the read
// one cycle later, and routes each out-of-order completion back to the
// requester owning its tag.
// Ports:
//   clk  clock
//   rst  synchronous reset, active-low (0 = reset)
//   bus  slave side of rmw_long_latency_rd_sched_if (requests, grants, table
//        read, completions, responses, busy/err status)
module rmw_long_latency_rd_sched #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 3,
    parameter int ID_W   = 8,
    parameter int WORD_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    rmw_long_latency_rd_sched_if.slave  bus
);
    localparam int NT    = 1 << TAG_W;
    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [NT-1:0]    tag_busy_r;
    logic [OWN_W-1:0] owner_r [NT];
    logic [OWN_W-1:0] rr_ptr_r;

    logic [OWN_W-1:0] win_idx_s;
    logic [TAG_W-1:0] free_idx_s;
    logic             grant_s;
    logic             cmp_hit_s;
    logic             cmp_miss_s;
    logic [NT-1:0]    tag_set_s;
    logic [NT-1:0]    tag_clr_s;
    logic [NT-1:0]    tag_busy_nxt_s;

    // Requester index at a given distance above base, wrapping at N_REQ.
    function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] base, input int ofs);
        rr_idx = OWN_W'((int'(base) + ofs) % N_REQ);
    endfunction

    // Round-robin winner and lowest free tag; searching downward lets the
    // closest candidate overwrite the farther ones.
    always_comb begin
        win_idx_s  = rr_ptr_r;
        free_idx_s = {TAG_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            win_idx_s = bus.req_vld_r[rr_idx(rr_ptr_r, k)] ? rr_idx(rr_ptr_r, k) : win_idx_s;
        end
        for (int t = NT - 1; t >= 0; t--) begin
            free_idx_s = tag_busy_r[t] ? free_idx_s : TAG_W'(t);
        end
    end

    // Grant qualification and tag-set bookkeeping; the completing tag is only
    // freed, never reallocated on the same edge, since allocation looks at the
    // pre-edge busy vector.
    always_comb begin
        grant_s        = rst && (|bus.req_vld_r) && !(&tag_busy_r);
        cmp_hit_s      = bus.tbl_rd_word_vld_r && tag_busy_r[bus.tbl_rd_ctag_r];
        cmp_miss_s     = bus.tbl_rd_word_vld_r && !tag_busy_r[bus.tbl_rd_ctag_r];
        tag_set_s      = {NT{1'b0}};
        tag_clr_s      = {NT{1'b0}};
        bus.req_rdy_w  = {N_REQ{1'b0}};
        if (grant_s) begin
            tag_set_s     = {{(NT-1){1'b0}}, 1'b1} << free_idx_s;
            bus.req_rdy_w = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        end else begin
            tag_set_s     = {NT{1'b0}};
            bus.req_rdy_w = {N_REQ{1'b0}};
        end
        if (cmp_hit_s) begin
            tag_clr_s = {{(NT-1){1'b0}}, 1'b1} << bus.tbl_rd_ctag_r;
        end else begin
            tag_clr_s = {NT{1'b0}};
        end
        tag_busy_nxt_s = (tag_busy_r & ~tag_clr_s) | tag_set_s;
    end

    // Tag state, issue, completion routing and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_busy_r        <= {NT{1'b0}};
            rr_ptr_r          <= {OWN_W{1'b0}};
            for (int t = 0; t < NT; t++) begin
                owner_r[t] <= {OWN_W{1'b0}};
            end
            bus.tbl_rd_r      <= 1'b0;
            bus.tbl_rd_id_r   <= {ID_W{1'b0}};
            bus.tbl_rd_itag_r <= {TAG_W{1'b0}};
            bus.rsp_vld_r     <= {N_REQ{1'b0}};
            bus.rsp_word_r    <= {WORD_W{1'b0}};
            bus.rsp_tag_r     <= {TAG_W{1'b0}};
            bus.busy_r        <= 1'b0;
            bus.err_r         <= 1'b0;
        end else begin
            tag_busy_r <= tag_busy_nxt_s;
            bus.busy_r <= |tag_busy_nxt_s;
            if (grant_s) begin
                bus.tbl_rd_r          <= 1'b1;
                bus.tbl_rd_id_r       <= bus.req_id_r[int'(win_idx_s) * ID_W +: ID_W];
                bus.tbl_rd_itag_r     <= free_idx_s;
                owner_r[free_idx_s]   <= win_idx_s;
                rr_ptr_r              <= rr_idx(win_idx_s, 1);
            end else begin
                bus.tbl_rd_r <= 1'b0;
            end
            if (cmp_hit_s) begin
                bus.rsp_vld_r  <= {{(N_REQ-1){1'b0}}, 1'b1} << owner_r[bus.tbl_rd_ctag_r];
                bus.rsp_word_r <= bus.tbl_rd_word_r;
                bus.rsp_tag_r  <= bus.tbl_rd_ctag_r;
            end else begin
                bus.rsp_vld_r  <= {N_REQ{1'b0}};
            end
            if (cmp_miss_s) begin
                bus.err_r <= 1'b1;
            end else begin
                bus.err_r <= bus.err_r;
            end
        end
    end
endmodule

// File: tb/tb_rmw_long_latency_rd_sched.sv
// Directed self-checking bench for rmw_long_latency_rd_sched (N_REQ=4, TAG_W=3).
module tb_rmw_long_latency_rd_sched;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rmw_long_latency_rd_sched_if #(.N_REQ(4), .TAG_W(3), .ID_W(8), .WORD_W(32)) bus ();

    rmw_long_latency_rd_sched #(.N_REQ(4), .TAG_W(3), .ID_W(8), .WORD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_vld_r         = 4'b0000;
        bus.req_id_r          = 32'h0;
        bus.tbl_rd_word_vld_r = 1'b0;
        bus.tbl_rd_word_r     = 32'h0;
        bus.tbl_rd_ctag_r     = 3'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        bus.req_vld_r = 4'b1111;
        cyc();
        cyc();
        settle();
        checks++;
        if (bus.req_rdy_w !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b want 0000", bus.req_rdy_w); end
        checks++;
        if (bus.tbl_rd_r !== 1'b0 || bus.rsp_vld_r !== 4'b0000) begin errors++; $display("FAIL reset_outs got rd=%b rsp=%b want 0/0000", bus.tbl_rd_r, bus.rsp_vld_r); end
        checks++;
        if (bus.busy_r !== 1'b0 || bus.err_r !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b err=%b want 0/0", bus.busy_r, bus.err_r); end
        rst = 1'b1;
        bus.req_vld_r = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        bus.req_vld_r = 4'b0001;
        bus.req_id_r  = {8'h00, 8'h00, 8'h00, 8'h12};
        settle();
        checks++;
        if (bus.req_rdy_w !== 4'b0001) begin errors++; $display("FAIL single_rdy got %b want 0001", bus.req_rdy_w); end
        cyc();
        bus.req_vld_r = 4'b0000;
        checks++;
        if (bus.tbl_rd_r !== 1'b1 || bus.tbl_rd_id_r !== 8'h12 || bus.tbl_rd_itag_r !== 3'd0)
            begin errors++; $display("FAIL single_issue got rd=%b id=%h itag=%0d want 1/12/0", bus.tbl_rd_r, bus.tbl_rd_id_r, bus.tbl_rd_itag_r); end
        checks++;
        if (bus.busy_r !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.busy_r); end
        bus.tbl_rd_word_vld_r = 1'b1;
        bus.tbl_rd_ctag_r     = 3'd0;
        bus.tbl_rd_word_r     = 32'h0000DEAD;
        cyc();
        bus.tbl_rd_word_vld_r = 1'b0;
        checks++;
        if (bus.rsp_vld_r !== 4'b0001 || bus.rsp_word_r !== 32'h0000DEAD || bus.rsp_tag_r !== 3'd0)
            begin errors++; $display("FAIL single_rsp got vld=%b word=%h tag=%0d want 0001/0000dead/0", bus.rsp_vld_r, bus.rsp_word_r, bus.rsp_tag_r); end
        checks++;
        if (bus.tbl_rd_r !== 1'b0 || bus.busy_r !== 1'b0 || bus.tbl_rd_id_r !== 8'h12)
            begin errors++; $display("FAIL single_idle got rd=%b busy=%b id=%h want 0/0/12", bus.tbl_rd_r, bus.busy_r, bus.tbl_rd_id_r); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_oh;
        do_reset();
        bus.req_vld_r = 4'b1111;
        bus.req_id_r  = {8'h23, 8'h22, 8'h21, 8'h20};
        for (int k = 0; k < 8; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            settle();
            checks++;
            if (bus.req_rdy_w !== exp_oh) begin errors++; $display("FAIL fair_rdy%0d got %b want %b", k, bus.req_rdy_w, exp_oh); end
            cyc();
            checks++;
            if (bus.tbl_rd_r !== 1'b1 || bus.tbl_rd_itag_r !== 3'(k) || bus.tbl_rd_id_r !== 8'(8'h20 + (k % 4)))
                begin errors++; $display("FAIL fair_issue%0d got rd=%b itag=%0d id=%h want 1/%0d/%h", k, bus.tbl_rd_r, bus.tbl_rd_itag_r, bus.tbl_rd_id_r, k, 8'(8'h20 + (k % 4))); end
        end
        bus.req_vld_r = 4'b0000;
    endtask

    task automatic test_exhaustion();
        do_reset();
        bus.req_vld_r = 4'b0001;
        bus.req_id_r  = {8'h00, 8'h00, 8'h00, 8'h30};
        for (int k = 0; k < 8; k++) cyc();
        settle();
        checks++;
        if (bus.req_rdy_w !== 4'b0000) begin errors++; $display("FAIL full_rdy got %b want 0000", bus.req_rdy_w); end
        cyc();
        checks++;
        if (bus.tbl_rd_r !== 1'b0 || bus.busy_r !== 1'b1) begin errors++; $display("FAIL full_noissue got rd=%b busy=%b want 0/1", bus.tbl_rd_r, bus.busy_r); end
        bus.tbl_rd_word_vld_r = 1'b1;
        bus.tbl_rd_ctag_r     = 3'd5;
        bus.tbl_rd_word_r     = 32'h00000055;
        settle();
        checks++;
        if (bus.req_rdy_w !== 4'b0000) begin errors++; $display("FAIL full_cmp_rdy got %b want 0000", bus.req_rdy_w); end
        cyc();
        bus.tbl_rd_word_vld_r = 1'b0;
        checks++;
        if (bus.rsp_vld_r !== 4'b0001 || bus.rsp_tag_r !== 3'd5 || bus.tbl_rd_r !== 1'b0)
            begin errors++; $display("FAIL full_rsp got vld=%b tag=%0d rd=%b want 0001/5/0", bus.rsp_vld_r, bus.rsp_tag_r, bus.tbl_rd_r); end
        settle();
        checks++;
        if (bus.req_rdy_w !== 4'b0001) begin errors++; $display("FAIL full_regrant_rdy got %b want 0001", bus.req_rdy_w); end
        cyc();
        checks++;
        if (bus.tbl_rd_r !== 1'b1 || bus.tbl_rd_itag_r !== 3'd5) begin errors++; $display("FAIL full_regrant got rd=%b itag=%0d want 1/5", bus.tbl_rd_r, bus.tbl_rd_itag_r); end
        settle();
        checks++;
        if (bus.req_rdy_w !== 4'b0000) begin errors++; $display("FAIL full_again_rdy got %b want 0000", bus.req_rdy_w); end
        bus.req_vld_r = 4'b0000;
    endtask

    task automatic test_out_of_order();
        logic [3:0] req_seq [3];
        logic [2:0] cmp_seq [3];
        logic [3:0] rsp_seq [3];
        req_seq = '{4'b0100, 4'b0001, 4'b1000};
        cmp_seq = '{3'd2, 3'd0, 3'd1};
        rsp_seq = '{4'b1000, 4'b0100, 4'b0001};
        do_reset();
        bus.req_id_r = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int k = 0; k < 3; k++) begin
            bus.req_vld_r = req_seq[k];
            cyc();
            checks++;
            if (bus.tbl_rd_r !== 1'b1 || bus.tbl_rd_itag_r !== 3'(k)) begin errors++; $display("FAIL ooo_issue%0d got rd=%b itag=%0d want 1/%0d", k, bus.tbl_rd_r, bus.tbl_rd_itag_r, k); end
        end
        bus.req_vld_r = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            bus.tbl_rd_word_vld_r = 1'b1;
            bus.tbl_rd_ctag_r     = cmp_seq[k];
            bus.tbl_rd_word_r     = 32'hA000_0000 + 32'(k);
            cyc();
            checks++;
            if (bus.rsp_vld_r !== rsp_seq[k] || bus.rsp_tag_r !== cmp_seq[k] || bus.rsp_word_r !== 32'hA000_0000 + 32'(k))
                begin errors++; $display("FAIL ooo_rsp%0d got vld=%b tag=%0d word=%h want %b/%0d/%h", k, bus.rsp_vld_r, bus.rsp_tag_r, bus.rsp_word_r, rsp_seq[k], cmp_seq[k], 32'hA000_0000 + 32'(k)); end
        end
        bus.tbl_rd_word_vld_r = 1'b0;
        checks++;
        if (bus.busy_r !== 1'b0) begin errors++; $display("FAIL ooo_busy got %b want 0", bus.busy_r); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req_vld_r = 4'b0001;
        bus.req_id_r  = {8'h00, 8'h00, 8'h00, 8'h77};
        cyc();
        bus.tbl_rd_word_vld_r = 1'b1;
        bus.tbl_rd_ctag_r     = 3'd0;
        bus.tbl_rd_word_r     = 32'h1234_5678;
        cyc();
        bus.tbl_rd_word_vld_r = 1'b0;
        bus.req_vld_r         = 4'b0000;
        checks++;
        if (bus.tbl_rd_r !== 1'b1 || bus.tbl_rd_itag_r !== 3'd1) begin errors++; $display("FAIL b2b_issue got rd=%b itag=%0d want 1/1", bus.tbl_rd_r, bus.tbl_rd_itag_r); end
        checks++;
        if (bus.rsp_vld_r !== 4'b0001 || bus.rsp_tag_r !== 3'd0 || bus.busy_r !== 1'b1)
            begin errors++; $display("FAIL b2b_rsp got vld=%b tag=%0d busy=%b want 0001/0/1", bus.rsp_vld_r, bus.rsp_tag_r, bus.busy_r); end
    endtask

    task automatic test_err_and_reset();
        do_reset();
        bus.tbl_rd_word_vld_r = 1'b1;
        bus.tbl_rd_ctag_r     = 3'd4;
        cyc();
        bus.tbl_rd_word_vld_r = 1'b0;
        checks++;
        if (bus.err_r !== 1'b1 || bus.rsp_vld_r !== 4'b0000) begin errors++; $display("FAIL err_free got err=%b rsp=%b want 1/0000", bus.err_r, bus.rsp_vld_r); end
        bus.req_vld_r = 4'b0010;
        bus.req_id_r  = {8'h00, 8'h00, 8'h51, 8'h50};
        cyc();
        cyc();
        cyc();
        bus.req_vld_r = 4'b0000;
        checks++;
        if (bus.busy_r !== 1'b1 || bus.err_r !== 1'b1 || bus.tbl_rd_itag_r !== 3'd2)
            begin errors++; $display("FAIL err_sticky got busy=%b err=%b itag=%0d want 1/1/2", bus.busy_r, bus.err_r, bus.tbl_rd_itag_r); end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        checks++;
        if (bus.busy_r !== 1'b0 || bus.err_r !== 1'b0 || bus.tbl_rd_r !== 1'b0)
            begin errors++; $display("FAIL midrst got busy=%b err=%b rd=%b want 0/0/0", bus.busy_r, bus.err_r, bus.tbl_rd_r); end
        bus.req_vld_r = 4'b0011;
        settle();
        checks++;
        if (bus.req_rdy_w !== 4'b0001) begin errors++; $display("FAIL midrst_rdy got %b want 0001", bus.req_rdy_w); end
        cyc();
        bus.req_vld_r = 4'b0000;
        checks++;
        if (bus.tbl_rd_r !== 1'b1 || bus.tbl_rd_itag_r !== 3'd0 || bus.tbl_rd_id_r !== 8'h50)
            begin errors++; $display("FAIL midrst_issue got rd=%b itag=%0d id=%h want 1/0/50", bus.tbl_rd_r, bus.tbl_rd_itag_r, bus.tbl_rd_id_r); end
        bus.tbl_rd_word_vld_r = 1'b1;
        bus.tbl_rd_ctag_r     = 3'd1;
        cyc();
        bus.tbl_rd_word_vld_r = 1'b0;
        checks++;
        if (bus.err_r !== 1'b1 || bus.rsp_vld_r !== 4'b0000) begin errors++; $display("FAIL stale_cmp got err=%b rsp=%b want 1/0000", bus.err_r, bus.rsp_vld_r); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_exhaustion();
        test_out_of_order();
        test_back_to_back();
        test_err_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
